// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase codes and lamp decode helpers for the
// intersection controller and any lamp-level modules.
package traffic_pkg;

  // Dwell counter width; every phase duration must fit below 2**CNT_W.
  localparam int CNT_W = 5;

  // Lamp encoding driven onto main_light / side_light.
  localparam logic [1:0] OFF = 2'd0;
  localparam logic [1:0] RED = 2'd1;
  localparam logic [1:0] YEL = 2'd2;
  localparam logic [1:0] GRN = 2'd3;

  // Phase codes, also exported on the debug phase port.
  typedef enum logic [2:0] {
    RED_TO_MAIN = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    RED_TO_SIDE = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5
  } phase_e;

  // Main-road lamp for a given phase; unused codes fall back to red.
  function automatic logic [1:0] main_lamp(input phase_e ph);
    case (ph)
      MAIN_GREEN:  return GRN;
      MAIN_YELLOW: return YEL;
      default:     return RED;
    endcase
  endfunction

  // Side-road lamp for a given phase; unused codes fall back to red.
  function automatic logic [1:0] side_lamp(input phase_e ph);
    case (ph)
      SIDE_GREEN:  return GRN;
      SIDE_YELLOW: return YEL;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for the current phase. Cleared on phase entry, counts every
// cycle, and flags done on the last cycle of the requested duration. With
// hold set it parks on the done value instead of running past it.
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] duration,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  // Count cycles spent in the phase; clear wins over counting and hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!(done && hold)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == duration - 1'b1);

endmodule

// File: rtl/intersection_phase_ctrl.sv
// Two-road intersection phase controller: main road rests in green, a latched
// side-road request moves through yellow and an all-red clearance to a side
// green that may be extended once while traffic keeps arriving.
module intersection_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TBASE = 6,
  parameter int TYEL  = 2,
  parameter int TEXT  = 3,
  parameter int TRED  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic [2:0] phase,
  output logic       side_req
);

  // Reject parameter sets the 5-bit dwell counter cannot time.
  if (TBASE < 1 || TYEL < 1 || TRED < 1 || TEXT < 0 ||
      2 * TBASE > 31 || TBASE + TEXT > 31) begin : g_bad_params
    $error("intersection_phase_ctrl: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] D_RED  = CNT_W'(TRED);
  localparam logic [CNT_W-1:0] D_MAIN = CNT_W'(2 * TBASE);
  localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(TYEL);
  localparam logic [CNT_W-1:0] D_SIDE = CNT_W'(TBASE);
  localparam logic [CNT_W-1:0] D_SEXT = CNT_W'(TBASE + TEXT);
  // A zero-length extension is simply no extension.
  localparam bit EXT_EN = (TEXT > 0);

  phase_e           state_reg;
  phase_e           state_next;
  logic             ext_reg;
  logic             ext_grant;
  logic             side_req_reg;
  logic [1:0]       main_light_reg;
  logic [1:0]       side_light_reg;
  logic [CNT_W-1:0] duration;
  logic             done;
  logic             timer_clear;
  logic             timer_hold;

  // Duration of the current phase; side green grows once extended.
  always_comb begin
    duration = D_RED;
    case (state_reg)
      RED_TO_MAIN, RED_TO_SIDE: duration = D_RED;
      MAIN_GREEN:               duration = D_MAIN;
      MAIN_YELLOW, SIDE_YELLOW: duration = D_YEL;
      SIDE_GREEN:               duration = ext_reg ? D_SEXT : D_SIDE;
      default:                  duration = D_RED;
    endcase
  end

  // Next-phase decision; every green is reached only through a RED_TO_* phase.
  always_comb begin
    state_next = state_reg;
    ext_grant  = 1'b0;
    case (state_reg)
      RED_TO_MAIN: if (done) state_next = MAIN_GREEN;
      MAIN_GREEN:  if (done && side_req_reg) state_next = MAIN_YELLOW;
      MAIN_YELLOW: if (done) state_next = RED_TO_SIDE;
      RED_TO_SIDE: if (done) state_next = SIDE_GREEN;
      SIDE_GREEN: begin
        if (done) begin
          if (EXT_EN && sensor && !ext_reg) ext_grant = 1'b1;
          else                              state_next = SIDE_YELLOW;
        end
      end
      SIDE_YELLOW: if (done) state_next = RED_TO_MAIN;
      default:     state_next = RED_TO_MAIN;
    endcase
    timer_clear = (state_next != state_reg);
    timer_hold  = (state_reg == MAIN_GREEN);
  end

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .hold     (timer_hold),
    .duration (duration),
    .done     (done)
  );

  // Phase register, extension flag, request latch and registered lamps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RED_TO_MAIN;
      ext_reg        <= 1'b0;
      side_req_reg   <= 1'b0;
      main_light_reg <= RED;
      side_light_reg <= RED;
    end else begin
      state_reg      <= state_next;
      main_light_reg <= main_lamp(state_next);
      side_light_reg <= side_lamp(state_next);
      if (timer_clear)    ext_reg <= 1'b0;
      else if (ext_grant) ext_reg <= 1'b1;
      // Entering side green serves the request, even if sensor is high now.
      if (timer_clear && state_next == SIDE_GREEN)
        side_req_reg <= 1'b0;
      else if (sensor && state_reg != SIDE_GREEN)
        side_req_reg <= 1'b1;
    end
  end

  assign main_light = main_light_reg;
  assign side_light = side_light_reg;
  assign phase      = state_reg;
  assign side_req   = side_req_reg;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Scenario bench for intersection_phase_ctrl: each scenario queues the
// expected lamp/phase/request timeline with its sensor stimulus, then pops
// one entry per clock and compares it against the outputs.
module tb_intersection_phase_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sensor = 1'b0;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic [2:0] phase;
  logic       side_req;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] m;
    logic [1:0] s;
    logic [2:0] ph;
    logic       rq;
  } exp_t;

  exp_t sb_q[$];
  bit   sens_q[$];

  intersection_phase_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sensor     (sensor),
    .main_light (main_light),
    .side_light (side_light),
    .phase      (phase),
    .side_req   (side_req)
  );

  always #5 clk = ~clk;

  // Queue n cycles of expected outputs, each with the sensor value applied
  // before the edge that produces it.
  task automatic push(input bit sens, input logic [1:0] m, input logic [1:0] s,
                      input logic [2:0] ph, input logic rq, input int n);
    exp_t e;
    e.m = m; e.s = s; e.ph = ph; e.rq = rq;
    for (int i = 0; i < n; i++) begin
      sens_q.push_back(sens);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sensor = 1'b0;
    sb_q.delete();
    sens_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got, want;
    want.m = RED; want.s = RED; want.ph = 3'd0; want.rq = 1'b0;
    reset = 1'b0;
    sensor = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {main_light, side_light, phase, side_req};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_held got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
    end
    sensor = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    got = {main_light, side_light, phase, side_req};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_release got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
    end
    $display("test_reset: red/red phase 0 during and after reset");
  endtask

  task automatic test_idle_main();
    exp_t got, want;
    int k = 0;
    push(0, GRN, RED, 3'd1, 1'b0, 40);
    while (sb_q.size() > 0) begin
      sensor = sens_q.pop_front();
      @(posedge clk); #1;
      k++;
      got  = {main_light, side_light, phase, side_req};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL idle_main[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
      end
    end
    $display("test_idle_main: %0d cycles of main green checked", k);
  endtask

  task automatic test_side_cycle();
    exp_t got, want;
    int k = 0;
    do_reset();
    push(0, GRN, RED, 3'd1, 1'b0, 2);
    push(1, GRN, RED, 3'd1, 1'b1, 1);
    push(0, GRN, RED, 3'd1, 1'b1, 9);
    push(0, YEL, RED, 3'd2, 1'b1, 2);
    push(0, RED, RED, 3'd3, 1'b1, 1);
    push(0, RED, GRN, 3'd4, 1'b0, 6);
    push(0, RED, YEL, 3'd5, 1'b0, 2);
    push(0, RED, RED, 3'd0, 1'b0, 1);
    push(0, GRN, RED, 3'd1, 1'b0, 10);
    while (sb_q.size() > 0) begin
      sensor = sens_q.pop_front();
      @(posedge clk); #1;
      k++;
      got  = {main_light, side_light, phase, side_req};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL side_cycle[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
      end
    end
    $display("test_side_cycle: %0d cycles of pulsed-request cycle checked", k);
  endtask

  task automatic test_sensor_held();
    exp_t got, want;
    int k = 0;
    do_reset();
    push(1, GRN, RED, 3'd1, 1'b1, 12);
    push(1, YEL, RED, 3'd2, 1'b1, 2);
    push(1, RED, RED, 3'd3, 1'b1, 1);
    push(1, RED, GRN, 3'd4, 1'b0, 9);
    push(1, RED, YEL, 3'd5, 1'b0, 1);
    push(1, RED, YEL, 3'd5, 1'b1, 1);
    push(1, RED, RED, 3'd0, 1'b1, 1);
    push(1, GRN, RED, 3'd1, 1'b1, 12);
    push(1, YEL, RED, 3'd2, 1'b1, 1);
    while (sb_q.size() > 0) begin
      sensor = sens_q.pop_front();
      @(posedge clk); #1;
      k++;
      got  = {main_light, side_light, phase, side_req};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sensor_held[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
      end
    end
    $display("test_sensor_held: %0d cycles with one extension checked", k);
  endtask

  task automatic test_ext_last_cycle();
    exp_t got, want;
    int k = 0;
    do_reset();
    push(0, GRN, RED, 3'd1, 1'b0, 2);
    push(1, GRN, RED, 3'd1, 1'b1, 1);
    push(0, GRN, RED, 3'd1, 1'b1, 9);
    push(0, YEL, RED, 3'd2, 1'b1, 2);
    push(0, RED, RED, 3'd3, 1'b1, 1);
    push(0, RED, GRN, 3'd4, 1'b0, 6);
    push(1, RED, GRN, 3'd4, 1'b0, 1);
    push(0, RED, GRN, 3'd4, 1'b0, 2);
    push(0, RED, YEL, 3'd5, 1'b0, 2);
    push(0, RED, RED, 3'd0, 1'b0, 1);
    push(0, GRN, RED, 3'd1, 1'b0, 15);
    while (sb_q.size() > 0) begin
      sensor = sens_q.pop_front();
      @(posedge clk); #1;
      k++;
      got  = {main_light, side_light, phase, side_req};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL ext_last_cycle[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
      end
    end
    $display("test_ext_last_cycle: %0d cycles, extension on final-cycle sensor", k);
  endtask

  task automatic test_reset_in_yellow();
    exp_t got, want;
    int k = 0;
    do_reset();
    push(0, GRN, RED, 3'd1, 1'b0, 2);
    push(1, GRN, RED, 3'd1, 1'b1, 1);
    push(0, GRN, RED, 3'd1, 1'b1, 9);
    push(0, YEL, RED, 3'd2, 1'b1, 1);
    while (sb_q.size() > 0) begin
      sensor = sens_q.pop_front();
      @(posedge clk); #1;
      k++;
      got  = {main_light, side_light, phase, side_req};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL yellow_lead[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
      end
    end
    // Assert reset between edges, well before the next rising edge.
    #2;
    reset = 1'b0;
    #1;
    want.m = RED; want.s = RED; want.ph = 3'd0; want.rq = 1'b0;
    got = {main_light, side_light, phase, side_req};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL async_reset got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
    end
    @(posedge clk); #1;
    got = {main_light, side_light, phase, side_req};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL async_reset_hold got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
    end
    @(negedge clk);
    reset = 1'b1;
    push(0, GRN, RED, 3'd1, 1'b0, 3);
    while (sb_q.size() > 0) begin
      sensor = sens_q.pop_front();
      @(posedge clk); #1;
      k++;
      got  = {main_light, side_light, phase, side_req};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL after_abort[%0d] got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 got.m, got.s, got.ph, got.rq, want.m, want.s, want.ph, want.rq);
      end
    end
    $display("test_reset_in_yellow: abort to red/red and restart checked");
  endtask

  task automatic test_random_safety();
    logic [1:0] pm, ps;
    int yel_run = 0;
    int yellows = 0;
    do_reset();
    pm = RED;
    ps = RED;
    for (int c = 0; c < 10000; c++) begin
      sensor = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      checks++;
      if (main_light != RED && side_light != RED) begin
        failures++;
        $display("FAIL both_nonred cycle %0d got main=%0d side=%0d want one red",
                 c, main_light, side_light);
      end
      if (main_light == GRN && pm != GRN) begin
        checks++;
        if (!(pm == RED && ps == RED)) begin
          failures++;
          $display("FAIL main_green_entry cycle %0d prev %0d/%0d want 1/1", c, pm, ps);
        end
      end
      if (side_light == GRN && ps != GRN) begin
        checks++;
        if (!(pm == RED && ps == RED)) begin
          failures++;
          $display("FAIL side_green_entry cycle %0d prev %0d/%0d want 1/1", c, pm, ps);
        end
      end
      if (main_light == YEL || side_light == YEL) begin
        yel_run++;
      end else if (yel_run > 0) begin
        checks++;
        yellows++;
        if (yel_run != 2) begin
          failures++;
          $display("FAIL yellow_len cycle %0d got %0d want 2", c, yel_run);
        end
        yel_run = 0;
      end
      pm = main_light;
      ps = side_light;
    end
    $display("test_random_safety: 10000 cycles, %0d yellow phases measured", yellows);
  endtask

  initial begin
    test_reset();
    test_idle_main();
    test_side_cycle();
    test_sensor_held();
    test_ext_last_cycle();
    test_reset_in_yellow();
    test_random_safety();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
